adder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-bit carry-select adder (`CSelectA_16_4`) among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and registers the 17-bit sum, tagged with the requester ID, into a single-entry output stage with backpressure. It sits between independent producers of add operations and their consumer.

---
 rtl/adder_arb_pkg.sv | 16 +
 rtl/CSelectA_16_4.sv | 29 ++
 rtl/rr_picker.sv | 38 +++
 rtl/adder_rr_arbiter.sv | 99 +++++++++
 tb/tb_adder_rr_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants, operand/result types and the round-robin pointer helper
// for the adder arbiter slice.
package adder_arb_pkg;

   localparam int ADD_W   = 16;
   localparam int MAX_REQ = 8;

   typedef logic [ADD_W-1:0] operand_t;
   typedef logic [ADD_W:0]   result_t;

   // Index of the requester that follows ptr in a ring of n requesters.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/CSelectA_16_4.sv
// 16-bit carry-select adder built from four 4-bit blocks, each computing both
// carry-in hypotheses up front and selecting once the real carry arrives.
module CSelectA_16_4 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_cout
);

   logic [4:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar gi = 0; gi < 4; gi++) begin : gBlk
      logic [4:0] w_sum0;
      logic [4:0] w_sum1;

      assign w_sum0 = {1'b0, i_a[gi*4 +: 4]} + {1'b0, i_b[gi*4 +: 4]};
      assign w_sum1 = {1'b0, i_a[gi*4 +: 4]} + {1'b0, i_b[gi*4 +: 4]} + 5'd1;

      // Only the mux sits on the carry chain; the block adds run in parallel.
      assign o_sum[gi*4 +: 4] = w_carry[gi] ? w_sum1[3:0] : w_sum0[3:0];
      assign w_carry[gi+1]    = w_carry[gi] ? w_sum1[4]   : w_sum0[4];
   end

   assign o_cout = w_carry[4];

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid requester at or after ptr,
// wrapping modulo N_REQ, reported as a one-hot grant plus its index.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_reqValid,
   input  logic [ID_W-1:0]  i_ptr,
   input  logic             i_enable,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_grantIdx
);

   logic            w_found;
   logic [ID_W:0]   w_slot;
   logic [ID_W-1:0] w_cand;

   // Walk the ring starting at ptr; the first valid hit wins.
   always_comb begin
      o_grant    = '0;
      o_grantIdx = '0;
      w_found    = 1'b0;
      w_slot     = '0;
      w_cand     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_slot = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_slot >= (ID_W+1)'(N_REQ))
            w_slot = w_slot - (ID_W+1)'(N_REQ);
         w_cand = w_slot[ID_W-1:0];
         if (i_enable && !w_found && i_reqValid[w_cand]) begin
            w_found          = 1'b1;
            o_grant[w_cand]  = 1'b1;
            o_grantIdx       = w_cand;
         end
      end
   end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one carry-select adder among N_REQ requesters with round-robin
// arbitration and a single-entry, backpressured result register.
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 16,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [ID_W-1:0]    resp_id,
   output logic [W:0]         resp_sum,
   output logic               busy
);

   if (W != ADD_W || N_REQ < 2 || N_REQ > MAX_REQ) begin : gCfgErr
      $error("adder_rr_arbiter: W must be 16 and N_REQ must be 2..8");
   end

   logic [ID_W-1:0]  r_ptr;
   logic             r_respValid;
   logic [ID_W-1:0]  r_respId;
   result_t          r_respSum;

   logic             w_outFree;
   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_grantIdx;
   logic             w_accept;
   operand_t         w_opA;
   operand_t         w_opB;
   operand_t         w_sum;
   logic             w_cout;

   assign w_outFree = !r_respValid || resp_ready;

   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .i_reqValid (req_valid),
      .i_ptr      (r_ptr),
      .i_enable   (w_outFree && !rst),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx)
   );

   assign w_accept = |w_grant;

   // Steer the granted requester's operands into the shared adder.
   always_comb begin
      w_opA = '0;
      w_opB = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_grantIdx == ID_W'(k)) begin
            w_opA = req_a[k*W +: W];
            w_opB = req_b[k*W +: W];
         end
      end
   end

   CSelectA_16_4 u_adder (
      .i_a    (w_opA),
      .i_b    (w_opB),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // A new accept overwrites the result even while it is being drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_respValid <= 1'b0;
         r_respId    <= '0;
         r_respSum   <= '0;
      end else if (w_accept) begin
         r_respValid <= 1'b1;
         r_respId    <= w_grantIdx;
         r_respSum   <= {w_cout, w_sum};
         r_ptr       <= ID_W'(rr_next(int'(w_grantIdx), N_REQ));
      end else if (r_respValid && resp_ready) begin
         r_respValid <= 1'b0;
      end
   end

   assign req_ready  = w_grant;
   assign resp_valid = r_respValid;
   assign resp_id    = r_respId;
   assign resp_sum   = r_respSum;
   assign busy       = r_respValid || (|req_valid);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-free
// ring-search reference model of the arbiter.
module tb_adder_rr_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   reqValid;
   logic [N*W-1:0] reqA;
   logic [N*W-1:0] reqB;
   logic [N-1:0]   reqReady;
   logic           respValid;
   logic           respReady;
   logic [IDW-1:0] respId;
   logic [W:0]     respSum;
   logic           busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adder_rr_arbiter #(
      .N_REQ (N),
      .W     (W),
      .ID_W  (IDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_a      (reqA),
      .req_b      (reqB),
      .req_ready  (reqReady),
      .resp_valid (respValid),
      .resp_ready (respReady),
      .resp_id    (respId),
      .resp_sum   (respSum),
      .busy       (busy)
   );

   // Guard against a stuck simulation.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
      reqValid  = v;
      respReady = rr;
   endtask

   task automatic setOp(input int i, input logic [15:0] a, input logic [15:0] b);
      reqA[i*W +: W] = a;
      reqB[i*W +: W] = b;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset;
      rst = 1'b1;
      applyStimulus('0, 1'b0);
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < N; i++) setOp(i, 16'(i + 1), 16'h0010);
      applyStimulus(4'hF, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected %b", reqReady, 4'b0000);
      end
      tick;
      tick;
      checks++;
      if (respValid !== 1'b0 || respSum !== 17'h0 || respId !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid=%b sum=%h id=%0d expected 0/0/0",
                  respValid, respSum, respId);
      end
      applyStimulus('0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_single;
      doReset;
      setOp(2, 16'hFFFF, 16'h0001);
      applyStimulus(4'b0100, 1'b0);
      #1;
      checks++;
      if (reqReady !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL single_grant: got %b expected %b", reqReady, 4'b0100);
      end
      tick;
      applyStimulus('0, 1'b0);
      checks++;
      if (respValid !== 1'b1 || respId !== 2'd2 || respSum !== 17'h10000) begin
         errors++;
         $display("[TB] FAIL single_result: got valid=%b id=%0d sum=%h expected 1/2/10000",
                  respValid, respId, respSum);
      end
      applyStimulus('0, 1'b1);
      tick;
   endtask

   task automatic test_contention;
      int order [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] expReady;
      doReset;
      for (int i = 0; i < N; i++) setOp(i, 16'(i), 16'd100);
      applyStimulus(4'hF, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         expReady = 4'b0001 << order[k];
         checks++;
         if (reqReady !== expReady) begin
            errors++;
            $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, reqReady, expReady);
         end
         tick;
         checks++;
         if (respValid !== 1'b1 || respId !== 2'(order[k]) || respSum !== 17'(100 + order[k])) begin
            errors++;
            $display("[TB] FAIL contention_result%0d: got valid=%b id=%0d sum=%0d expected 1/%0d/%0d",
                     k, respValid, respId, respSum, order[k], 100 + order[k]);
         end
      end
      applyStimulus('0, 1'b1);
      tick;
   endtask

   task automatic test_backpressure;
      doReset;
      for (int i = 0; i < N; i++) setOp(i, 16'(16'h1000 * i + 5), 16'd7);
      applyStimulus(4'hF, 1'b0);
      #1;
      checks++;
      if (reqReady !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL bp_first_grant: got %b expected %b", reqReady, 4'b0001);
      end
      tick;
      applyStimulus(4'hE, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (reqReady !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bp_stall_ready%0d: got %b expected %b", k, reqReady, 4'b0000);
         end
         tick;
         checks++;
         if (respValid !== 1'b1 || respId !== 2'd0 || respSum !== 17'd12) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b id=%0d sum=%0d expected 1/0/12",
                     k, respValid, respId, respSum);
         end
      end
      applyStimulus(4'hE, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL bp_release_grant: got %b expected %b", reqReady, 4'b0010);
      end
      tick;
      checks++;
      if (respValid !== 1'b1 || respId !== 2'd1 || respSum !== 17'h0100C) begin
         errors++;
         $display("[TB] FAIL bp_replace: got valid=%b id=%0d sum=%h expected 1/1/0100c",
                  respValid, respId, respSum);
      end
      applyStimulus('0, 1'b1);
      tick;
   endtask

   task automatic test_pointer_hold;
      doReset;
      setOp(3, 16'h0003, 16'h0004);
      applyStimulus(4'b1000, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL ptr_grant3: got %b expected %b", reqReady, 4'b1000);
      end
      tick;
      applyStimulus('0, 1'b1);
      tick;
      tick;
      setOp(0, 16'd10, 16'd20);
      setOp(1, 16'd30, 16'd40);
      applyStimulus(4'b0011, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL ptr_wrap_grant: got %b expected %b", reqReady, 4'b0001);
      end
      tick;
      checks++;
      if (respId !== 2'd0 || respSum !== 17'd30) begin
         errors++;
         $display("[TB] FAIL ptr_wrap_result: got id=%0d sum=%0d expected 0/30", respId, respSum);
      end
      applyStimulus(4'b0010, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL ptr_next_grant: got %b expected %b", reqReady, 4'b0010);
      end
      tick;
      applyStimulus('0, 1'b1);
      tick;
   endtask

   task automatic test_drain;
      doReset;
      setOp(1, 16'h8000, 16'h8001);
      applyStimulus(4'b0010, 1'b0);
      tick;
      applyStimulus('0, 1'b0);
      #1;
      checks++;
      if (respValid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drain_loaded: got valid=%b busy=%b expected 1/1", respValid, busy);
      end
      applyStimulus('0, 1'b1);
      tick;
      checks++;
      if (respValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_empty: got valid=%b busy=%b expected 0/0", respValid, busy);
      end
      checks++;
      if (respId !== 2'd1 || respSum !== 17'h10001) begin
         errors++;
         $display("[TB] FAIL drain_keep: got id=%0d sum=%h expected 1/10001", respId, respSum);
      end
   endtask

   task automatic test_reset_mid;
      doReset;
      setOp(2, 16'd100, 16'd200);
      applyStimulus(4'b0100, 1'b0);
      tick;
      applyStimulus('0, 1'b0);
      checks++;
      if (respValid !== 1'b1 || respSum !== 17'd300) begin
         errors++;
         $display("[TB] FAIL midrst_loaded: got valid=%b sum=%0d expected 1/300", respValid, respSum);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if (respValid !== 1'b0 || respSum !== 17'h0 || respId !== 2'd0) begin
         errors++;
         $display("[TB] FAIL midrst_cleared: got valid=%b sum=%h id=%0d expected 0/0/0",
                  respValid, respSum, respId);
      end
      for (int i = 0; i < N; i++) setOp(i, 16'(i), 16'(i));
      applyStimulus(4'hF, 1'b1);
      #1;
      checks++;
      if (reqReady !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL midrst_first_grant: got %b expected %b", reqReady, 4'b0001);
      end
      tick;
      applyStimulus('0, 1'b1);
      tick;
   endtask

   // Random producers obey the hold-until-ready rule; the model searches the
   // ring by plain modular arithmetic and tracks one result slot.
   task automatic test_random;
      int          mPtr;
      logic        mValid;
      logic [16:0] mSum;
      int          mId;
      logic        pend [N];
      logic [15:0] opA [N];
      logic [15:0] opB [N];
      logic [N-1:0] pendVec;
      logic [N-1:0] expReady;
      logic        rr;
      logic        expBusy;
      int          g;
      int          idx;
      doReset;
      mPtr = 0;
      mValid = 1'b0;
      mSum = '0;
      mId = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         opA[i] = '0;
         opB[i] = '0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               opA[i]  = 16'($urandom);
               opB[i]  = 16'($urandom);
               setOp(i, opA[i], opB[i]);
            end
            pendVec[i] = pend[i];
         end
         rr = ($urandom_range(0, 3) != 0);
         applyStimulus(pendVec, rr);
         #1;
         g = -1;
         if (!mValid || rr) begin
            for (int k = 0; k < N; k++) begin
               idx = (mPtr + k) % N;
               if (g < 0 && pend[idx]) g = idx;
            end
         end
         expReady = (g < 0) ? 4'b0000 : (4'b0001 << g);
         expBusy  = mValid || (|pendVec);
         checks++;
         if (reqReady !== expReady || busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL rand_ready@%0d: got ready=%b busy=%b expected ready=%b busy=%b",
                     cyc, reqReady, busy, expReady, expBusy);
         end
         tick;
         if (g >= 0) begin
            mSum    = {1'b0, opA[g]} + {1'b0, opB[g]};
            mId     = g;
            mValid  = 1'b1;
            mPtr    = (g + 1) % N;
            pend[g] = 1'b0;
         end else if (mValid && rr) begin
            mValid = 1'b0;
         end
         checks++;
         if (respValid !== mValid || respId !== 2'(mId) || respSum !== mSum) begin
            errors++;
            $display("[TB] FAIL rand_resp@%0d: got valid=%b id=%0d sum=%h expected valid=%b id=%0d sum=%h",
                     cyc, respValid, respId, respSum, mValid, mId, mSum);
         end
      end
      applyStimulus('0, 1'b1);
      tick;
   endtask

   initial begin
      rst       = 1'b1;
      reqValid  = '0;
      reqA      = '0;
      reqB      = '0;
      respReady = 1'b0;
      test_reset;
      test_single;
      test_contention;
      test_backpressure;
      test_pointer_hold;
      test_drain;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
